// File: rtl/alu_rs_pkg.sv
// ============================================================================
// Module      : alu_rs_pkg
// Description : Shared definitions for the ALU reservation station: opcode
//               encoding, datapath widths and common constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_rs_pkg;

    localparam int WORD      = 32;
    localparam int ROB_IDX   = 4;
    localparam int OPT_WIDTH = 6;

    localparam logic FALSE = 1'b0;
    localparam logic TRUE  = 1'b1;

    localparam logic [WORD-1:0] ZERO_WORD = '0;

    // Internal ALU/branch opcode encoding
    localparam logic [OPT_WIDTH-1:0] OPT_NONE = 6'd0;
    localparam logic [OPT_WIDTH-1:0] OPT_ADD  = 6'd1;
    localparam logic [OPT_WIDTH-1:0] OPT_SUB  = 6'd2;
    localparam logic [OPT_WIDTH-1:0] OPT_AND  = 6'd3;
    localparam logic [OPT_WIDTH-1:0] OPT_OR   = 6'd4;
    localparam logic [OPT_WIDTH-1:0] OPT_XOR  = 6'd5;
    localparam logic [OPT_WIDTH-1:0] OPT_SLL  = 6'd6;
    localparam logic [OPT_WIDTH-1:0] OPT_SRL  = 6'd7;
    localparam logic [OPT_WIDTH-1:0] OPT_SRA  = 6'd8;
    localparam logic [OPT_WIDTH-1:0] OPT_SLT  = 6'd9;
    localparam logic [OPT_WIDTH-1:0] OPT_SLTU = 6'd10;
    localparam logic [OPT_WIDTH-1:0] OPT_BEQ  = 6'd11;
    localparam logic [OPT_WIDTH-1:0] OPT_BNE  = 6'd12;
    localparam logic [OPT_WIDTH-1:0] OPT_BLT  = 6'd13;
    localparam logic [OPT_WIDTH-1:0] OPT_BGE  = 6'd14;
    localparam logic [OPT_WIDTH-1:0] OPT_JALR = 6'd15;

endpackage

`default_nettype wire

// File: rtl/alu_rs_if.sv
// ============================================================================
// Module      : alu_rs_if
// Description : Bus bundle between dispatch/CDB/ALU and the ALU reservation
//               station. The "slave" modport is the reservation station side,
//               "master" is the surrounding pipeline.
//               Groups: disp_* (dispatch request, rs_full back-pressure),
//               cdb_alu_* / cdb_lsu_* (result broadcasts), iss_* (issue bus).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_rs_if #(
    parameter int ROB_W = 4,
    parameter int OPT_W = 6
) ();
    import alu_rs_pkg::*;

    logic             disp_valid;
    logic [OPT_W-1:0] disp_opt;
    logic [ROB_W-1:0] disp_qj;
    logic [WORD-1:0]  disp_vj;
    logic [ROB_W-1:0] disp_qk;
    logic [WORD-1:0]  disp_vk;
    logic [WORD-1:0]  disp_imm;
    logic [ROB_W-1:0] disp_rob_idx;
    logic             rs_full;

    logic             cdb_alu_valid;
    logic [ROB_W-1:0] cdb_alu_src;
    logic [WORD-1:0]  cdb_alu_val;
    logic             cdb_lsu_valid;
    logic [ROB_W-1:0] cdb_lsu_src;
    logic [WORD-1:0]  cdb_lsu_val;

    logic             iss_valid;
    logic [OPT_W-1:0] iss_opt;
    logic [WORD-1:0]  iss_val1;
    logic [WORD-1:0]  iss_val2;
    logic [WORD-1:0]  iss_imm;
    logic [ROB_W-1:0] iss_rob_idx;

    modport master (
        output disp_valid, disp_opt, disp_qj, disp_vj, disp_qk, disp_vk,
               disp_imm, disp_rob_idx,
        output cdb_alu_valid, cdb_alu_src, cdb_alu_val,
               cdb_lsu_valid, cdb_lsu_src, cdb_lsu_val,
        input  rs_full,
        input  iss_valid, iss_opt, iss_val1, iss_val2, iss_imm, iss_rob_idx
    );

    modport slave (
        input  disp_valid, disp_opt, disp_qj, disp_vj, disp_qk, disp_vk,
               disp_imm, disp_rob_idx,
        input  cdb_alu_valid, cdb_alu_src, cdb_alu_val,
               cdb_lsu_valid, cdb_lsu_src, cdb_lsu_val,
        output rs_full,
        output iss_valid, iss_opt, iss_val1, iss_val2, iss_imm, iss_rob_idx
    );

endinterface

`default_nettype wire

// File: rtl/alu_rs_pick.sv
// ============================================================================
// Module      : alu_rs_pick
// Description : Lowest-index priority encoder. Reports whether any request
//               bit is set and the index of the lowest set bit.
//               Ports: req (N request bits) -> found, idx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rs_pick #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  wire logic [N-1:0]     req,
    output logic                  found,
    output logic [IDX_W-1:0]      idx
);
    import alu_rs_pkg::*;

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        found = FALSE;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = TRUE;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_rs.sv
// ============================================================================
// Module      : alu_rs
// Description : Reservation station / issue scheduler for the integer ALU.
//               Buffers dispatched micro-ops until both operands are known,
//               snoops the ALU and LSU CDBs for wakeup, and issues the
//               lowest-index ready entry on a registered issue bus.
//               Ports: clk, rst (sync, active high), rdy (global stall when
//               low), flush (misprediction clear), bus (alu_rs_if.slave).
//               Build option: ALU_RS_BYPASS_EN lets a fully-ready dispatch
//               skip the entry array and issue directly when no stored
//               entry is ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rs #(
    parameter int RS_SIZE = 8,
    parameter int ROB_W   = 4,
    parameter int OPT_W   = 6
) (
    input  wire logic  clk,
    input  wire logic  rst,
    input  wire logic  rdy,
    input  wire logic  flush,
    alu_rs_if.slave    bus
);
    import alu_rs_pkg::*;

    localparam int               c_idx_w  = $clog2(RS_SIZE);
    localparam logic [ROB_W-1:0] c_no_tag = '0;

    // Entry storage
    logic [RS_SIZE-1:0] r_busy;
    logic [OPT_W-1:0]   r_opt [RS_SIZE];
    logic [ROB_W-1:0]   r_qj  [RS_SIZE];
    logic [WORD-1:0]    r_vj  [RS_SIZE];
    logic [ROB_W-1:0]   r_qk  [RS_SIZE];
    logic [WORD-1:0]    r_vk  [RS_SIZE];
    logic [WORD-1:0]    r_imm [RS_SIZE];
    logic [ROB_W-1:0]   r_rob [RS_SIZE];

    // Issue registers
    logic               r_iss_valid;
    logic [OPT_W-1:0]   r_iss_opt;
    logic [WORD-1:0]    r_iss_val1;
    logic [WORD-1:0]    r_iss_val2;
    logic [WORD-1:0]    r_iss_imm;
    logic [ROB_W-1:0]   r_iss_rob;

    logic [RS_SIZE-1:0] w_ready;
    logic               w_free_found;
    logic [c_idx_w-1:0] w_free_idx;
    logic               w_iss_found;
    logic [c_idx_w-1:0] w_iss_idx;
    logic               w_disp_ok;
    logic               w_bypass;
    logic [ROB_W-1:0]   w_dqj;
    logic [WORD-1:0]    w_dvj;
    logic [ROB_W-1:0]   w_dqk;
    logic [WORD-1:0]    w_dvk;

    // A waiting tag is satisfied by a valid broadcast of the same tag; tag 0
    // means "already have the value" and must never match.
    function automatic logic cdb_hit(input logic v, input logic [ROB_W-1:0] src,
                                     input logic [ROB_W-1:0] q);
        return v && (q != c_no_tag) && (src == q);
    endfunction

    for (genvar g = 0; g < RS_SIZE; g++) begin : g_ready
        assign w_ready[g] = r_busy[g] && (r_qj[g] == c_no_tag) && (r_qk[g] == c_no_tag);
    end

    alu_rs_pick #(.N(RS_SIZE), .IDX_W(c_idx_w)) u_pick_free (
        .req   (~r_busy),
        .found (w_free_found),
        .idx   (w_free_idx)
    );

    alu_rs_pick #(.N(RS_SIZE), .IDX_W(c_idx_w)) u_pick_issue (
        .req   (w_ready),
        .found (w_iss_found),
        .idx   (w_iss_idx)
    );

    // Operands of the incoming op after same-cycle CDB capture
    always_comb begin
        w_dqj = bus.disp_qj;
        w_dvj = bus.disp_vj;
        w_dqk = bus.disp_qk;
        w_dvk = bus.disp_vk;
        if (cdb_hit(bus.cdb_alu_valid, bus.cdb_alu_src, bus.disp_qj)) begin
            w_dqj = c_no_tag;
            w_dvj = bus.cdb_alu_val;
        end else if (cdb_hit(bus.cdb_lsu_valid, bus.cdb_lsu_src, bus.disp_qj)) begin
            w_dqj = c_no_tag;
            w_dvj = bus.cdb_lsu_val;
        end
        if (cdb_hit(bus.cdb_alu_valid, bus.cdb_alu_src, bus.disp_qk)) begin
            w_dqk = c_no_tag;
            w_dvk = bus.cdb_alu_val;
        end else if (cdb_hit(bus.cdb_lsu_valid, bus.cdb_lsu_src, bus.disp_qk)) begin
            w_dqk = c_no_tag;
            w_dvk = bus.cdb_lsu_val;
        end
    end

    // A free slot exists exactly when rs_full is low.
    assign w_disp_ok = bus.disp_valid && w_free_found;

`ifdef ALU_RS_BYPASS_EN
    // Stored ready entries always win the issue slot over a bypassing op.
    assign w_bypass = w_disp_ok && (w_dqj == c_no_tag) && (w_dqk == c_no_tag) && !w_iss_found;
`else
    assign w_bypass = FALSE;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= '0;
            r_iss_valid <= FALSE;
            r_iss_opt   <= '0;
            r_iss_val1  <= ZERO_WORD;
            r_iss_val2  <= ZERO_WORD;
            r_iss_imm   <= ZERO_WORD;
            r_iss_rob   <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_busy      <= '0;
                r_iss_valid <= FALSE;
            end else begin
                // Wakeup; an entry being issued already has both tags clear.
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (r_busy[i]) begin
                        if (cdb_hit(bus.cdb_alu_valid, bus.cdb_alu_src, r_qj[i])) begin
                            r_qj[i] <= c_no_tag;
                            r_vj[i] <= bus.cdb_alu_val;
                        end else if (cdb_hit(bus.cdb_lsu_valid, bus.cdb_lsu_src, r_qj[i])) begin
                            r_qj[i] <= c_no_tag;
                            r_vj[i] <= bus.cdb_lsu_val;
                        end
                        if (cdb_hit(bus.cdb_alu_valid, bus.cdb_alu_src, r_qk[i])) begin
                            r_qk[i] <= c_no_tag;
                            r_vk[i] <= bus.cdb_alu_val;
                        end else if (cdb_hit(bus.cdb_lsu_valid, bus.cdb_lsu_src, r_qk[i])) begin
                            r_qk[i] <= c_no_tag;
                            r_vk[i] <= bus.cdb_lsu_val;
                        end
                    end
                end

                if (w_iss_found) begin
                    r_busy[w_iss_idx] <= FALSE;
                    r_iss_valid       <= TRUE;
                    r_iss_opt         <= r_opt[w_iss_idx];
                    r_iss_val1        <= r_vj[w_iss_idx];
                    r_iss_val2        <= r_vk[w_iss_idx];
                    r_iss_imm         <= r_imm[w_iss_idx];
                    r_iss_rob         <= r_rob[w_iss_idx];
                end else if (w_bypass) begin
                    r_iss_valid <= TRUE;
                    r_iss_opt   <= bus.disp_opt;
                    r_iss_val1  <= w_dvj;
                    r_iss_val2  <= w_dvk;
                    r_iss_imm   <= bus.disp_imm;
                    r_iss_rob   <= bus.disp_rob_idx;
                end else begin
                    r_iss_valid <= FALSE;
                end

                // The free slot is never the issuing slot, so both can happen.
                if (w_disp_ok && !w_bypass) begin
                    r_busy[w_free_idx] <= TRUE;
                    r_opt[w_free_idx]  <= bus.disp_opt;
                    r_qj[w_free_idx]   <= w_dqj;
                    r_vj[w_free_idx]   <= w_dvj;
                    r_qk[w_free_idx]   <= w_dqk;
                    r_vk[w_free_idx]   <= w_dvk;
                    r_imm[w_free_idx]  <= bus.disp_imm;
                    r_rob[w_free_idx]  <= bus.disp_rob_idx;
                end
            end
        end
    end

    assign bus.rs_full     = &r_busy;
    assign bus.iss_valid   = r_iss_valid;
    assign bus.iss_opt     = r_iss_opt;
    assign bus.iss_val1    = r_iss_val1;
    assign bus.iss_val2    = r_iss_val2;
    assign bus.iss_imm     = r_iss_imm;
    assign bus.iss_rob_idx = r_iss_rob;

endmodule

`default_nettype wire

// File: tb/tb_alu_rs.sv
// ============================================================================
// Module      : tb_alu_rs
// Description : Self-checking bench for alu_rs. A reference model predicts
//               each issued op and pushes it, tagged with its cycle, into a
//               scoreboard queue; a monitor compares the issue bus against it.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_rs;
    import alu_rs_pkg::*;

    localparam int RS_SIZE = 8;
    localparam int ROB_W   = 4;
    localparam int OPT_W   = 6;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic flush;

    alu_rs_if #(.ROB_W(ROB_W), .OPT_W(OPT_W)) bus ();

    alu_rs #(.RS_SIZE(RS_SIZE), .ROB_W(ROB_W), .OPT_W(OPT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [5:0]  opt;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [3:0]  rob;
    } exp_t;

    typedef struct {
        bit          busy;
        logic [5:0]  opt;
        int          qj;
        logic [31:0] vj;
        int          qk;
        logic [31:0] vk;
        logic [31:0] imm;
        logic [3:0]  rob;
    } ment_t;

    exp_t  sb [$];
    ment_t m [RS_SIZE];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    bit    mon_en = 1'b0;

    function automatic bit hit(input logic v, input logic [3:0] src, input int q);
        return (v === 1'b1) && (q != 0) && (int'(src) == q);
    endfunction

    // ---------------- reference model ----------------
    initial begin
        ment_t pre [RS_SIZE];
        int    pick;
        int    freei;
        bit    full;
        bit    issued;
        int    dqj, dqk;
        logic [31:0] dvj, dvk;
        exp_t  e;
        exp_t  last_exp;
        bit    last_valid;
        last_valid = 1'b0;
        last_exp   = '{0, 6'd0, 32'd0, 32'd0, 32'd0, 4'd0};
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
                sb.delete();
                last_valid = 1'b0;
            end else if (!rdy) begin
                // Frozen: the issue bus keeps showing whatever it showed.
                if (last_valid) begin
                    last_exp.cyc = cyc;
                    sb.push_back(last_exp);
                end
            end else if (flush) begin
                for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
                last_valid = 1'b0;
            end else begin
                pre    = m;
                pick   = -1;
                freei  = -1;
                full   = 1'b1;
                issued = 1'b0;
                for (int i = RS_SIZE - 1; i >= 0; i--) begin
                    if (pre[i].busy && pre[i].qj == 0 && pre[i].qk == 0) pick = i;
                    if (!pre[i].busy) begin
                        freei = i;
                        full  = 1'b0;
                    end
                end
                dqj = int'(bus.disp_qj); dvj = bus.disp_vj;
                dqk = int'(bus.disp_qk); dvk = bus.disp_vk;
                if (hit(bus.cdb_alu_valid, bus.cdb_alu_src, dqj)) begin dqj = 0; dvj = bus.cdb_alu_val; end
                else if (hit(bus.cdb_lsu_valid, bus.cdb_lsu_src, dqj)) begin dqj = 0; dvj = bus.cdb_lsu_val; end
                if (hit(bus.cdb_alu_valid, bus.cdb_alu_src, dqk)) begin dqk = 0; dvk = bus.cdb_alu_val; end
                else if (hit(bus.cdb_lsu_valid, bus.cdb_lsu_src, dqk)) begin dqk = 0; dvk = bus.cdb_lsu_val; end

                if (pick >= 0) begin
                    e = '{cyc, pre[pick].opt, pre[pick].vj, pre[pick].vk, pre[pick].imm, pre[pick].rob};
                    sb.push_back(e);
                    last_exp   = e;
                    issued     = 1'b1;
                    m[pick].busy = 1'b0;
                end
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (pre[i].busy && i != pick) begin
                        if (hit(bus.cdb_alu_valid, bus.cdb_alu_src, pre[i].qj)) begin m[i].qj = 0; m[i].vj = bus.cdb_alu_val; end
                        else if (hit(bus.cdb_lsu_valid, bus.cdb_lsu_src, pre[i].qj)) begin m[i].qj = 0; m[i].vj = bus.cdb_lsu_val; end
                        if (hit(bus.cdb_alu_valid, bus.cdb_alu_src, pre[i].qk)) begin m[i].qk = 0; m[i].vk = bus.cdb_alu_val; end
                        else if (hit(bus.cdb_lsu_valid, bus.cdb_lsu_src, pre[i].qk)) begin m[i].qk = 0; m[i].vk = bus.cdb_lsu_val; end
                    end
                end
                if (bus.disp_valid && !full) begin
`ifdef ALU_RS_BYPASS_EN
                    if (!issued && dqj == 0 && dqk == 0) begin
                        e = '{cyc, bus.disp_opt, dvj, dvk, bus.disp_imm, bus.disp_rob_idx};
                        sb.push_back(e);
                        last_exp = e;
                        issued   = 1'b1;
                    end else
`endif
                    m[freei] = '{1'b1, bus.disp_opt, dqj, dvj, dqk, dvk, bus.disp_imm, bus.disp_rob_idx};
                end
                last_valid = issued;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        bit   exp_v;
        bit   exp_full;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_full = 1'b1;
                for (int i = 0; i < RS_SIZE; i++) if (!m[i].busy) exp_full = 1'b0;
                n_checks++;
                if (bus.rs_full !== exp_full) begin
                    n_fail++;
                    $display("FAIL rs_full cyc=%0d got=%b want=%b", cyc, bus.rs_full, exp_full);
                end
                exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
                n_checks++;
                if (bus.iss_valid !== exp_v) begin
                    n_fail++;
                    $display("FAIL iss_valid cyc=%0d got=%b want=%b", cyc, bus.iss_valid, exp_v);
                end
                if (exp_v) begin
                    e = sb.pop_front();
                    if (bus.iss_valid === 1'b1) begin
                        n_checks++;
                        if ({bus.iss_opt, bus.iss_val1, bus.iss_val2, bus.iss_imm, bus.iss_rob_idx}
                            !== {e.opt, e.v1, e.v2, e.imm, e.rob}) begin
                            n_fail++;
                            $display("FAIL issue_data cyc=%0d got opt=%h v1=%h v2=%h imm=%h rob=%h want opt=%h v1=%h v2=%h imm=%h rob=%h",
                                     cyc, bus.iss_opt, bus.iss_val1, bus.iss_val2, bus.iss_imm, bus.iss_rob_idx,
                                     e.opt, e.v1, e.v2, e.imm, e.rob);
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        bus.disp_valid    = 1'b0;
        bus.disp_opt      = '0;
        bus.disp_qj       = '0;
        bus.disp_vj       = '0;
        bus.disp_qk       = '0;
        bus.disp_vk       = '0;
        bus.disp_imm      = '0;
        bus.disp_rob_idx  = '0;
        bus.cdb_alu_valid = 1'b0;
        bus.cdb_alu_src   = '0;
        bus.cdb_alu_val   = '0;
        bus.cdb_lsu_valid = 1'b0;
        bus.cdb_lsu_src   = '0;
        bus.cdb_lsu_val   = '0;
        flush             = 1'b0;
        rdy               = 1'b1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic disp(input logic [5:0] opt, input logic [3:0] qj, input logic [31:0] vj,
                        input logic [3:0] qk, input logic [31:0] vk, input logic [31:0] imm,
                        input logic [3:0] rob);
        bus.disp_valid   = 1'b1;
        bus.disp_opt     = opt;
        bus.disp_qj      = qj;
        bus.disp_vj      = vj;
        bus.disp_qk      = qk;
        bus.disp_vk      = vk;
        bus.disp_imm     = imm;
        bus.disp_rob_idx = rob;
    endtask

    task automatic cdb_alu(input logic [3:0] src, input logic [31:0] val);
        bus.cdb_alu_valid = 1'b1;
        bus.cdb_alu_src   = src;
        bus.cdb_alu_val   = val;
    endtask

    task automatic cdb_lsu(input logic [3:0] src, input logic [31:0] val);
        bus.cdb_lsu_valid = 1'b1;
        bus.cdb_lsu_src   = src;
        bus.cdb_lsu_val   = val;
    endtask

    task automatic chk_reset(input string name, input logic [31:0] got);
        n_checks++;
        if (got !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_%s got=%h want=0", name, got);
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick(3);
        chk_reset("iss_valid", {31'd0, bus.iss_valid});
        chk_reset("iss_opt",   {26'd0, bus.iss_opt});
        chk_reset("iss_val1",  bus.iss_val1);
        chk_reset("iss_val2",  bus.iss_val2);
        chk_reset("iss_imm",   bus.iss_imm);
        chk_reset("iss_rob",   {28'd0, bus.iss_rob_idx});
        chk_reset("rs_full",   {31'd0, bus.rs_full});
        rst    = 1'b0;
        mon_en = 1'b1;
        tick(1);

        // Ready ADD
        disp(OPT_ADD, 4'd0, 32'd5, 4'd0, 32'd7, 32'd0, 4'd3);
        tick(1); idle(); tick(4);

        // SUB waiting on tag 2, woken by the ALU CDB
        disp(OPT_SUB, 4'd2, 32'd0, 4'd0, 32'd1, 32'h20, 4'd4);
        tick(1); idle(); tick(2);
        cdb_alu(4'd2, 32'h10);
        tick(1); idle(); tick(3);

        // Fill all entries waiting on tag 4, then one ignored dispatch
        for (int i = 0; i < RS_SIZE; i++) begin
            disp(OPT_XOR, 4'd4, 32'd0, 4'd0, 32'(i + 100), 32'(i), 4'(i + 1));
            tick(1);
        end
        disp(OPT_OR, 4'd0, 32'd1, 4'd0, 32'd2, 32'd3, 4'd15);
        tick(1); idle(); tick(2);
        cdb_lsu(4'd4, 32'h44);
        tick(1); idle(); tick(10);

        // Same-cycle capture of operand 2
        disp(OPT_AND, 4'd0, 32'd1, 4'd6, 32'd0, 32'd9, 4'd5);
        cdb_alu(4'd6, 32'hAB);
        tick(1); idle(); tick(3);

        // Three woken entries, then flush with a simultaneous dispatch
        for (int i = 0; i < 3; i++) begin
            disp(OPT_SLL, 4'd9, 32'd0, 4'd0, 32'(i), 32'd0, 4'(i + 1));
            tick(1);
        end
        idle();
        cdb_alu(4'd9, 32'h99);
        tick(1); idle();
        flush = 1'b1;
        disp(OPT_ADD, 4'd0, 32'd1, 4'd0, 32'd1, 32'd0, 4'd7);
        tick(1); idle(); tick(5);

        // Stall with a ready entry and a pending wakeup
        disp(OPT_SLT, 4'd5, 32'd0, 4'd0, 32'd3, 32'd0, 4'd9);
        tick(1);
        disp(OPT_ADD, 4'd0, 32'd11, 4'd0, 32'd12, 32'd0, 4'd6);
        tick(1); idle();
        rdy = 1'b0;
        cdb_lsu(4'd5, 32'h55);
        tick(3); idle(); tick(3);
        cdb_lsu(4'd5, 32'h56);
        tick(1); idle(); tick(3);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            idle();
            if ($urandom_range(0, 9) < 6)
                disp(6'($urandom_range(1, 15)),
                     ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 7)), $urandom,
                     ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 7)) : 4'd0, $urandom,
                     $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) cdb_alu(4'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 4) < 2) begin
                cdb_lsu(4'($urandom_range(0, 7)), $urandom);
                if (bus.cdb_alu_valid && bus.cdb_lsu_src == bus.cdb_alu_src) bus.cdb_lsu_valid = 1'b0;
            end
            if ($urandom_range(0, 49) == 0) flush = 1'b1;
            if ($urandom_range(0, 9) == 0) rdy = 1'b0;
            tick(1);
        end
        idle();
        flush = 1'b1;
        tick(1); idle(); tick(3);

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
